// File: rtl/mac_acc.sv
// Signed Q-format multiply-accumulate producer: two-stage product/accumulate pipeline with a
// run-length FSM and sticky error flags. Define MAC_ACC_SAT_EN for a saturating accumulator.
module mac_acc #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                busy,
    output logic [2*N-1:0]      qacc,
    output logic                qsload,
    output logic                sum_err,
    output logic                mult_err
);

    localparam int W = 2 * N;
    localparam logic signed [N-1:0] OP_MIN = {1'b1, {(N-1){1'b0}}};
`ifdef MAC_ACC_SAT_EN
    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    // qacc keeps the product's 2Q fractional bits, so Q only needs to be a sane Q-format split.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("mac_acc: Q must lie in [0, N-1]");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic signed [W-1:0] prod_q, prod_d;
    logic                prod_vld_q;
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] sum;
    logic                ovf;
    logic                sum_err_q, sum_err_d;
    logic                mult_err_q, mult_err_d;
    logic                start_ok;
    logic                xfer;
    logic                last_xfer;

    assign start_ok  = (state_q == IDLE) && start;
    assign in_ready  = (state_q == RUN) && (cnt_q < len_q);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (cnt_q == len_q - LEN_W'(1));

    // Operands are sign-extended first so the low W bits of the product are the exact signed result.
    assign prod_d = W'(a) * W'(b);

    assign sum = acc_q + prod_q;
    assign ovf = (acc_q[W-1] == prod_q[W-1]) && (sum[W-1] != acc_q[W-1]);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
            RUN:     if (last_xfer) state_d = DRAIN;
            DRAIN:   if (!prod_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sum_err_d  = sum_err_q;
        mult_err_d = mult_err_q;
        if (start_ok) begin
            len_d      = len;
            cnt_d      = '0;
            acc_d      = '0;
            sum_err_d  = 1'b0;
            mult_err_d = 1'b0;
        end else begin
            if (xfer) begin
                cnt_d = cnt_q + LEN_W'(1);
                if (a == OP_MIN && b == OP_MIN) mult_err_d = 1'b1;
            end
            if (prod_vld_q) begin
`ifdef MAC_ACC_SAT_EN
                acc_d = ovf ? (prod_q[W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
                acc_d = sum;
`endif
                if (ovf) sum_err_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            sum_err_q  <= 1'b0;
            mult_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            prod_vld_q <= xfer;
            if (xfer) prod_q <= prod_d;
            acc_q      <= acc_d;
            sum_err_q  <= sum_err_d;
            mult_err_q <= mult_err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign qsload   = (state_q == DONE);
    assign qacc     = acc_q;
    assign sum_err  = sum_err_q;
    assign mult_err = mult_err_q;

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: the driver pushes model results per run, a monitor pops them on
// every qsload strobe and checks sum, flags and strobe timing.
module tb_mac_acc;

    localparam int N     = 16;
    localparam int Q     = 8;
    localparam int LEN_W = 8;
    localparam int W     = 2 * N;
    localparam longint ACC_MAXV  = (longint'(1) <<< (W - 1)) - 1;
    localparam longint ACC_MINV  = -(longint'(1) <<< (W - 1));
    localparam longint PROD_MAXV = (longint'(1) <<< (W - 2)) - 1;
    localparam longint PROD_MINV = -(longint'(1) <<< (W - 2));

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic                in_valid;
    logic                in_ready;
    logic                busy;
    logic [W-1:0]        qacc;
    logic                qsload;
    logic                sum_err;
    logic                mult_err;

    mac_acc #(.N(N), .Q(Q), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .qacc     (qacc),
        .qsload   (qsload),
        .sum_err  (sum_err),
        .mult_err (mult_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] qacc;
        logic         se;
        logic         me;
        int           due;  // rising edge on which the strobe is sampled high
    } exp_t;

    exp_t                sb_q[$];
    int                  n_cmp  = 0;
    int                  n_fail = 0;
    logic signed [N-1:0] op_a[256];
    logic signed [N-1:0] op_b[256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum of products, range-checked against the W-bit signed range.
    function automatic exp_t model(input int n);
        exp_t                e;
        longint              acc;
        longint              p;
        logic signed [W-1:0] wrapped;
        acc   = 0;
        e.se  = 1'b0;
        e.me  = 1'b0;
        e.due = 0;
        for (int i = 0; i < n; i++) begin
            p = longint'(op_a[i]) * longint'(op_b[i]);
            if (p > PROD_MAXV || p < PROD_MINV) e.me = 1'b1;
            acc = acc + p;
            if (acc > ACC_MAXV || acc < ACC_MINV) begin
                e.se = 1'b1;
`ifdef MAC_ACC_SAT_EN
                acc = (acc > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
`else
                wrapped = acc[W-1:0];
                acc     = longint'(wrapped);
`endif
            end
        end
        e.qacc = acc[W-1:0];
        return e;
    endfunction

    // gap < 0 picks a random 0..2 bubble between pairs; abort_after > 0 resets after that transfer.
    task automatic run(input int n, input int gap, input bit poke_start, input bit start_at_done,
                       input int abort_after);
        exp_t e;
        int   start_edge;
        int   last_edge;
        bit   got;
        e = model(n);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk); #1;
        start      = 1'b0;
        start_edge = cyc;
        check("busy_after_start", busy, 1);
        if (n == 0) begin
            e.due = start_edge + 1;
            sb_q.push_back(e);
            check("in_ready_len0", in_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            a        = op_a[i];
            b        = op_b[i];
            in_valid = 1'b1;
            got      = 1'b0;
            for (int w = 0; w < 64 && !got; w++) begin
                @(negedge clk);
                got = in_ready;
            end
            if (!got) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid  = 1'b0;
            last_edge = cyc;
            if (i + 1 == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_in_ready", in_ready, 0);
                check("abort_busy", busy, 0);
                check("abort_qacc", qacc, 0);
                check("abort_qsload", qsload, 0);
                check("abort_sum_err", sum_err, 0);
                check("abort_mult_err", mult_err, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (i == n - 1) begin
                e.due = last_edge + 3;
                sb_q.push_back(e);
            end else begin
                if (poke_start && i == 1) begin
                    start = 1'b1;
                    len   = LEN_W'(1);
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                repeat ((gap < 0) ? int'($urandom_range(2, 0)) : gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        @(negedge clk);
        check("in_ready_after_last", in_ready, 0);
        check("busy_after_last", busy, 1);
        for (int w = 0; w < 32; w++) begin
            if (!busy) break;
            if (start_at_done && qsload) begin
                start = 1'b1;
                len   = '0;
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_end", busy, 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                op_a[i] = {1'b1, {(N-1){1'b0}}};
                op_b[i] = {1'b1, {(N-1){1'b0}}};
            end else begin
                op_a[i] = N'($urandom);
                op_b[i] = N'($urandom);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && qsload === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_qsload", qsload, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("qacc", qacc, e.qacc);
                    check("sum_err", sum_err, e.se);
                    check("mult_err", mult_err, e.me);
                    check("qsload_edge", cyc + 1, e.due);
                    check("busy_at_qsload", busy, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_qacc", qacc, 0);
        check("rst_qsload", qsload, 0);
        check("rst_sum_err", sum_err, 0);
        check("rst_mult_err", mult_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5*2.0 + 1.0*1.0 + (-1.0)*0.5 = 3.5
        op_a[0] = 16'sh0180; op_b[0] = 16'sh0200;
        op_a[1] = 16'sh0100; op_b[1] = 16'sh0100;
        op_a[2] = 16'shFF00; op_b[2] = 16'sh0080;
        run(3, 0, 1'b0, 1'b1, 0);
        run(3, 2, 1'b0, 1'b0, 0);
        run(0, 0, 1'b0, 1'b0, 0);

        op_a[0] = 16'sh8000; op_b[0] = 16'sh8000;
        op_a[1] = 16'sh8000; op_b[1] = 16'sh8000;
        run(2, 0, 1'b0, 1'b0, 0);

        fill_random(4);
        run(4, -1, 1'b1, 1'b0, 0);

        fill_random(5);
        run(5, 0, 1'b0, 1'b0, 2);
        repeat (10) @(posedge clk);
        #1;
        check("post_abort_busy", busy, 0);
        run(5, 0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 16; r++) begin
            int n;
            n = int'($urandom_range(16, 1));
            fill_random(n);
            run(n, -1, 1'b0, (r % 4) == 0, 0);
        end

        fill_random(255);
        run(255, 0, 1'b0, 1'b0, 0);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
